bcd_scan_display: RTL
=====================

# bcd_scan_display

Parametrised successor to the team's combinational binary-to-BCD seven-segment converter. It converts a WIDTH-bit unsigned binary value to DIGITS packed BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock, under a start/busy/done handshake. It then time-multiplexes the held result onto a common-anode seven-segment display. It sits between the datapath result registers and the board display pins.

## Interface
- WIDTH, 14: binary input width (≥4).
- DIGITS, 4: BCD digits produced and scanned (1–8).
- REFRESH_DIV, 16: clock cycles each digit stays selected (≥2).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high; wins over all other inputs.
- start  in  1  request conversion of d_in; sampled only in IDLE.
- d_in  in  WIDTH  unsigned binary value.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; bcd_out/overflow valid and updated.
- overflow  out  1  last accepted d_in exceeded 10^DIGITS−1.
- bcd_out  out  4*DIGITS  held BCD result; digit 0 = bits [3:0] = least significant.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit enables, active-low one-hot.

## Operation
- States: IDLE, SHIFT. No other states.
- IDLE & start: latch d_in into shift register, clear BCD scratch, load bit counter = WIDTH, compare d_in > 10^DIGITS−1 into pending-overflow, go to SHIFT.
- SHIFT, each cycle: every scratch digit ≥5 gets +3, then {scratch, shift reg} shifts left 1; counter decrements. Last shift (counter 1→0): bcd_out ← scratch (or all 9s if pending-overflow), overflow ← pending-overflow, done = 1, go to IDLE.
- Scratch is 4*DIGITS bits; high bits lost on overflow are irrelevant because bcd_out saturates to all 9s.
- start while busy: ignored, no queueing. d_in changes during SHIFT: no effect.
- start in the done cycle (state is IDLE): accepted; back-to-back conversions are allowed.
- bcd_out and overflow change only on the done cycle, so the display never shows partial results.
- Scan: refresh counter 0..REFRESH_DIV−1; on wrap, digit index advances 0→DIGITS−1→0. an = ~(1<<index). seg = decode(bcd_out digit[index]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10–15 decode to 1111111.
- Scan runs continuously, independent of conversion state.

## Timing
- Reset values: state IDLE, busy 0, done 0, overflow 0, bcd_out 0, refresh counter 0, index 0, an = ~1, seg = 1000000.
- start sampled at edge k → busy = 1 after edge k; shifts occur at edges k+1..k+WIDTH; after edge k+WIDTH, busy = 0, done = 1 for exactly one cycle, and bcd_out is valid. Latency is WIDTH+1 edges from start to done.
- rst mid-conversion: after the reset edge, state is IDLE, no done pulse, bcd_out = 0, overflow = 0.
- Each an value is held for exactly REFRESH_DIV cycles; a full frame is DIGITS*REFRESH_DIV cycles.

## Configuration
- LEADING_ZERO_BLANK_EN defined: any digit above the most-significant non-zero digit of bcd_out shows seg = 1111111 while its an is still driven. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all DIGITS digits are decoded, including leading zeros.

## Test plan
- After rst, d_in = 11, start for one cycle → busy high 14 cycles, done pulse after edge k+14, bcd_out = 16'h0011, overflow = 0.
- d_in = 9999 → bcd_out = 16'h9999, overflow 0. Then d_in = 0 started in the done cycle → accepted, next bcd_out = 16'h0000.
- d_in = 16383 → overflow = 1, bcd_out = 16'h9999. A following d_in = 42 → overflow = 0, bcd_out = 16'h0042.
- Start with d_in = 123, then start held high with d_in = 456 during busy → only one done pulse, bcd_out = 16'h0123.
- Scan with REFRESH_DIV = 4 and bcd_out = 16'h1234 → an cycles 1110, 1101, 1011, 0111, each for 4 cycles, with seg 0011001, 0110000, 0100100, 1111001 respectively. With LEADING_ZERO_BLANK_EN defined and bcd_out = 16'h0042 → seg = 1111111 while an = 1011 and 0111.
- Assert rst at the 5th SHIFT cycle of a conversion → busy 0 on the next cycle, no done pulse, bcd_out = 0, an = 1110.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Iterative binary-to-BCD converter (double-dabble, one bit per clock) with a
// multiplexed common-anode seven-segment scanner. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_scan_display #(
    parameter int WIDTH       = 14,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      d_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 1);

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pend_ovf_q, pend_ovf_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [RW-1:0]       ref_q, ref_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       scratch_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        scratch_sh = {adj[BW-2:0], shift_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d    = d_in;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                    pend_ovf_d = (64'(d_in) > MAX_VAL);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_sh;
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    // Saturate so the display never shows a truncated value.
                    bcd_d   = pend_ovf_q ? {DIGITS{4'h9}} : scratch_sh;
                    ovf_d   = pend_ovf_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        int  msd;
        logic blank;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = i;
        end
`ifdef LEADING_ZERO_BLANK_EN
        blank = (int'(idx_q) > msd);
`else
        blank = 1'b0;
`endif
        seg = blank ? 7'b1111111 : decode(bcd_q[4*idx_q +: 4]);
        an  = ~(DIGITS'(1) << idx_q);
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;

endmodule
